// File: rtl/ring_counter_param_if.sv
// Control and status bundle for ring_counter_param: the sequencer drives the
// controls (master), the counter returns its state and decoded status (slave).
interface ring_counter_param_if #(
  parameter int WIDTH = 5
);
  localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             enable;
  logic [1:0]       mode;
  logic             dir;
  logic             inject;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             onehot_ok;
  logic [POS_W-1:0] pos;

  modport master (
    output enable, mode, dir, inject, load, load_value,
    input  q, wrap, onehot_ok, pos
  );

  modport slave (
    input  enable, mode, dir, inject, load, load_value,
    output q, wrap, onehot_ok, pos
  );
endinterface

// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson shift counter with parallel load, registered
// wrap pulse and combinational one-hot / highest-set-bit status.
module ring_counter_param #(
  parameter int          WIDTH = 5,
  parameter logic [31:0] INIT  = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 clear,
  ring_counter_param_if.slave bus
);
  localparam int               POS_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] INIT_Q = INIT[WIDTH-1:0];

  typedef enum logic [1:0] {
    MODE_RING     = 2'b00,
    MODE_JOHNSON  = 2'b01,
    MODE_HOLD     = 2'b10,
    MODE_HOLD_ALT = 2'b11
  } mode_e;

  function automatic logic [5:0] ones_count(input logic [WIDTH-1:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

  // Highest set bit wins because later (higher) indices overwrite earlier ones.
  function automatic logic [POS_W-1:0] high_index(input logic [WIDTH-1:0] v);
    logic [POS_W-1:0] idx;
    idx = {POS_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        idx = POS_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] q_next_s;
  logic             wrap_next_s;
  logic [WIDTH-1:0] shifted_s;
  logic             exit_s;
  logic             entry_s;
  logic             advance_s;
  logic             wrap_cond_s;
  mode_e            mode_s;

  assign mode_s = mode_e'(bus.mode);

  // Shift datapath: exit bit, entry bit and the advanced state.
  always_comb begin
    exit_s      = 1'b0;
    entry_s     = 1'b0;
    advance_s   = 1'b0;
    wrap_cond_s = 1'b0;
    shifted_s   = q_r;
    if (bus.dir) begin
      exit_s = q_r[WIDTH-1];
    end else begin
      exit_s = q_r[0];
    end
    case (mode_s)
      MODE_RING: begin
        entry_s   = exit_s | bus.inject;
        advance_s = bus.enable;
      end
      MODE_JOHNSON: begin
        entry_s   = ~exit_s | bus.inject;
        advance_s = bus.enable;
      end
      default: begin
        entry_s   = 1'b0;
        advance_s = 1'b0;
      end
    endcase
    if (bus.dir) begin
      shifted_s = {q_r[WIDTH-2:0], entry_s};
    end else begin
      shifted_s = {entry_s, q_r[WIDTH-1:1]};
    end
    // Ring laps on a recirculated token; Johnson laps when the shift empties q.
    case (mode_s)
      MODE_RING:    wrap_cond_s = exit_s;
      MODE_JOHNSON: wrap_cond_s = (shifted_s == {WIDTH{1'b0}});
      default:      wrap_cond_s = 1'b0;
    endcase
  end

  // Next-state selection: load beats advance beats hold.
  always_comb begin
    q_next_s    = q_r;
    wrap_next_s = 1'b0;
    if (bus.load) begin
      q_next_s    = bus.load_value;
      wrap_next_s = 1'b0;
    end else if (advance_s) begin
      q_next_s    = shifted_s;
      wrap_next_s = wrap_cond_s;
    end else begin
      q_next_s    = q_r;
      wrap_next_s = 1'b0;
    end
  end

  // State and wrap pulse registers, asynchronously cleared to INIT.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q_r    <= INIT_Q;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  assign bus.q         = q_r;
  assign bus.wrap      = wrap_r;
  assign bus.onehot_ok = (ones_count(q_r) == 6'd1);
  assign bus.pos       = high_index(q_r);
endmodule

// File: tb/tb_ring_counter_param.sv
// Directed bench for ring_counter_param: a 5-stage and an 8-stage (INIT=01)
// counter share controls and are compared every cycle against a value model.
module tb_ring_counter_param;
  logic       clk;
  logic       clear;
  logic [7:0] lv8;
  logic       chk_en;
  int         pass_cnt;
  int         total_cnt;

  ring_counter_param_if #(.WIDTH(5)) if5 ();
  ring_counter_param_if #(.WIDTH(8)) if8 ();

  ring_counter_param #(.WIDTH(5), .INIT(32'h0000_0000)) dut5 (
    .clk(clk), .clear(clear), .bus(if5.slave)
  );
  ring_counter_param #(.WIDTH(8), .INIT(32'h0000_0001)) dut8 (
    .clk(clk), .clear(clear), .bus(if8.slave)
  );

  assign if8.enable     = if5.enable;
  assign if8.mode       = if5.mode;
  assign if8.dir        = if5.dir;
  assign if8.inject     = if5.inject;
  assign if8.load       = if5.load;
  assign if8.load_value = lv8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value-level model: the counter as a w-bit number shifted one place,
  // with the vacated stage refilled by the ring/Johnson entry rule.
  function automatic logic [32:0] model_step(input int w, input logic [31:0] cur,
      input logic en, input logic [1:0] md, input logic dr, input logic inj,
      input logic ld, input logic [31:0] lv);
    logic [31:0] mask;
    logic [31:0] nxt;
    logic        ex;
    logic        ent;
    logic        wr;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    nxt  = cur;
    wr   = 1'b0;
    if (ld) begin
      nxt = lv & mask;
    end else if (en && (md == 2'b00 || md == 2'b01)) begin
      ex  = dr ? cur[w-1] : cur[0];
      ent = ((md == 2'b00) ? ex : ~ex) | inj;
      if (dr) nxt = ((cur << 1) | 32'(ent)) & mask;
      else    nxt = (cur >> 1) | (32'(ent) << (w - 1));
      wr = (md == 2'b00) ? ex : (nxt == 32'd0);
    end
    return {wr, nxt};
  endfunction

  function automatic logic [31:0] hi_idx(input logic [31:0] v);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) if (v[i]) r = 32'(i);
    return r;
  endfunction

  logic [31:0] m5_q, m8_q, m5_n, m8_n;
  logic        m5_w, m8_w, m5_wn, m8_wn;

  assign {m5_wn, m5_n} = model_step(5, m5_q, if5.enable, if5.mode, if5.dir,
                                    if5.inject, if5.load, 32'(if5.load_value));
  assign {m8_wn, m8_n} = model_step(8, m8_q, if5.enable, if5.mode, if5.dir,
                                    if5.inject, if5.load, 32'(lv8));

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      m5_q <= 32'd0;
      m5_w <= 1'b0;
      m8_q <= 32'h0000_0001;
      m8_w <= 1'b0;
    end else begin
      m5_q <= m5_n;
      m5_w <= m5_wn;
      m8_q <= m8_n;
      m8_w <= m8_wn;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cmp5.q",      32'(if5.q),         m5_q);
        chk("cmp5.wrap",   32'(if5.wrap),      32'(m5_w));
        chk("cmp5.onehot", 32'(if5.onehot_ok), 32'($countones(m5_q) == 1));
        chk("cmp5.pos",    32'(if5.pos),       hi_idx(m5_q));
        chk("cmp8.q",      32'(if8.q),         m8_q);
        chk("cmp8.wrap",   32'(if8.wrap),      32'(m8_w));
        chk("cmp8.onehot", 32'(if8.onehot_ok), 32'($countones(m8_q) == 1));
        chk("cmp8.pos",    32'(if8.pos),       hi_idx(m8_q));
      end
    end
  end

  task automatic ec(input string nm, input logic [4:0] eq, input logic ew);
    @(posedge clk);
    #1;
    chk({nm, ".q"},    32'(if5.q),    32'(eq));
    chk({nm, ".wrap"}, 32'(if5.wrap), 32'(ew));
  endtask

  initial begin
    logic [4:0]  t1_q   [0:5];
    logic [31:0] t1_pos [0:5];
    logic [4:0]  t2_q   [0:5];
    logic [4:0]  jq     [0:9];
    pass_cnt = 0;
    total_cnt = 0;
    chk_en = 1'b0;
    clear = 1'b1;
    lv8 = 8'h00;
    if5.enable = 1'b0;
    if5.mode = 2'b00;
    if5.dir = 1'b0;
    if5.inject = 1'b0;
    if5.load = 1'b0;
    if5.load_value = 5'b00000;
    t1_q   = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
    t1_pos = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd4};
    t2_q   = '{5'b10100, 5'b01010, 5'b00101, 5'b10010, 5'b01001, 5'b10100};
    jq     = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111,
               5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};

    #2 clear = 1'b0;
    #1;
    chk("rst5.q",      32'(if5.q),         32'h00);
    chk("rst5.wrap",   32'(if5.wrap),      32'd0);
    chk("rst5.onehot", 32'(if5.onehot_ok), 32'd0);
    chk("rst5.pos",    32'(if5.pos),       32'd0);
    chk("rst8.q",      32'(if8.q),         32'h01);
    chk("rst8.onehot", 32'(if8.onehot_ok), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold5.q", 32'(if5.q), 32'h00);
    chk_en = 1'b1;
    @(negedge clk);
    clear = 1'b1;

    // Single token lap, ring dir=0.
    if5.enable = 1'b1;
    if5.inject = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ec("lap1", t1_q[i], (i == 5));
      chk("lap1.pos",    32'(if5.pos),       t1_pos[i]);
      chk("lap1.onehot", 32'(if5.onehot_ok), 32'd1);
      if5.inject = 1'b0;
    end

    // Second token injected while q=01000.
    ec("lap2.pre", 5'b01000, 1'b0);
    if5.inject = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ec("lap2", t2_q[i], (i == 3 || i == 5));
      if5.inject = 1'b0;
    end
    chk("lap2.onehot", 32'(if5.onehot_ok), 32'd0);

    // Johnson full period from 00000.
    if5.load = 1'b1;
    if5.load_value = 5'b00000;
    if5.enable = 1'b0;
    ec("jload", 5'b00000, 1'b0);
    if5.load = 1'b0;
    if5.mode = 2'b01;
    if5.enable = 1'b1;
    for (int i = 0; i < 10; i++) ec("john", jq[i], (i == 9));

    // Ring dir=1 from 00001 with an enable gap.
    if5.load = 1'b1;
    if5.load_value = 5'b00001;
    if5.mode = 2'b00;
    if5.dir = 1'b1;
    ec("d1load", 5'b00001, 1'b0);
    if5.load = 1'b0;
    ec("d1", 5'b00010, 1'b0);
    ec("d1", 5'b00100, 1'b0);
    if5.enable = 1'b0;
    ec("d1.hold", 5'b00100, 1'b0);
    if5.enable = 1'b1;
    ec("d1", 5'b01000, 1'b0);
    ec("d1", 5'b10000, 1'b0);
    ec("d1", 5'b00001, 1'b1);

    // Load beats enable/inject; hold modes freeze q.
    if5.load = 1'b1;
    if5.inject = 1'b1;
    if5.load_value = 5'b00110;
    ec("ldwin", 5'b00110, 1'b0);
    if5.load = 1'b0;
    if5.mode = 2'b10;
    repeat (3) ec("hold10", 5'b00110, 1'b0);
    if5.mode = 2'b11;
    ec("hold11", 5'b00110, 1'b0);

    // Async clear during a wrap cycle.
    if5.inject = 1'b0;
    if5.mode = 2'b00;
    if5.dir = 1'b0;
    if5.load = 1'b1;
    if5.load_value = 5'b00001;
    lv8 = 8'h01;
    ec("clrload", 5'b00001, 1'b0);
    if5.load = 1'b0;
    ec("clrwrap", 5'b10000, 1'b1);
    chk("clrwrap8.q", 32'(if8.q), 32'h80);
    #2 clear = 1'b0;
    #1;
    chk("aclr5.q",    32'(if5.q),    32'h00);
    chk("aclr5.wrap", 32'(if5.wrap), 32'd0);
    chk("aclr8.q",    32'(if8.q),    32'h01);
    chk("aclr8.wrap", 32'(if8.wrap), 32'd0);
    ec("aclr_held", 5'b00000, 1'b0);
    chk("aclr_held8.q", 32'(if8.q), 32'h01);
    @(negedge clk);
    clear = 1'b1;
    ec("nostart", 5'b00000, 1'b0);
    chk("rel8.q",    32'(if8.q),    32'h80);
    chk("rel8.wrap", 32'(if8.wrap), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
